// File: rtl/tube_ctrl_param_pkg.sv
// -----------------------------------------------------------------------------
// tube_ctrl_param_pkg
// Shared parameters header for the multiplexed seven-segment tube driver.
// Holds the default scan divider and blink period, the glyph table and the
// blink phase type.
//
// Glyph layout (active-high): bit 7 = a, 6 = b, 5 = c, 4 = d, 3 = e, 2 = f,
// 1 = g, bit 0 = decimal point. Bit 0 is clear in every glyph so the decimal
// point can be ORed in independently.
// -----------------------------------------------------------------------------
package tube_ctrl_param_pkg;

    // Default clk cycles per digit slot (100 MHz clock -> 0.5 ms per digit).
    localparam int TUBE_SCAN_DIV     = 50000;
    // Default number of frames per blink half-period.
    localparam int TUBE_BLINK_FRAMES = 64;

    localparam logic [7:0] GLYPH_ZERO  = 8'hFC;
    localparam logic [7:0] GLYPH_ONE   = 8'h60;
    localparam logic [7:0] GLYPH_TWO   = 8'hDA;
    localparam logic [7:0] GLYPH_THREE = 8'hF2;
    localparam logic [7:0] GLYPH_FOUR  = 8'h66;
    localparam logic [7:0] GLYPH_FIVE  = 8'hB6;
    localparam logic [7:0] GLYPH_SIX   = 8'hBE;
    localparam logic [7:0] GLYPH_SEVEN = 8'hE0;
    localparam logic [7:0] GLYPH_EIGHT = 8'hFE;
    localparam logic [7:0] GLYPH_NINE  = 8'hF6;
    localparam logic [7:0] GLYPH_A     = 8'hEE;
    localparam logic [7:0] GLYPH_B     = 8'h3E;
    localparam logic [7:0] GLYPH_C     = 8'h9C;
    localparam logic [7:0] GLYPH_D     = 8'h7A;
    localparam logic [7:0] GLYPH_E     = 8'h9E;
    localparam logic [7:0] GLYPH_F     = 8'h8E;
    localparam logic [7:0] GLYPH_BLANK = 8'h00;

    // Blink phase: blinking digits are dark while the phase is PHASE_OFF.
    typedef enum logic {
        PHASE_OFF = 1'b0,
        PHASE_ON  = 1'b1
    } blinkPhase_t;

endpackage

// File: rtl/tube_ctrl_param_hex_glyph.sv
// -----------------------------------------------------------------------------
// hex_glyph
// Combinational hex nibble to seven-segment glyph decoder. The decimal point
// bit (bit 0) of the result is always clear.
//
// Ports:
//   nibble_i  in   4  hex value to display
//   glyph_o   out  8  active-high segment pattern
// -----------------------------------------------------------------------------
module hex_glyph
    import tube_ctrl_param_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] glyph_o
);

    // Straight table lookup into the shared glyph constants.
    always_comb begin
        glyph_o = GLYPH_BLANK;
        case (nibble_i)
            4'h0:    glyph_o = GLYPH_ZERO;
            4'h1:    glyph_o = GLYPH_ONE;
            4'h2:    glyph_o = GLYPH_TWO;
            4'h3:    glyph_o = GLYPH_THREE;
            4'h4:    glyph_o = GLYPH_FOUR;
            4'h5:    glyph_o = GLYPH_FIVE;
            4'h6:    glyph_o = GLYPH_SIX;
            4'h7:    glyph_o = GLYPH_SEVEN;
            4'h8:    glyph_o = GLYPH_EIGHT;
            4'h9:    glyph_o = GLYPH_NINE;
            4'hA:    glyph_o = GLYPH_A;
            4'hB:    glyph_o = GLYPH_B;
            4'hC:    glyph_o = GLYPH_C;
            4'hD:    glyph_o = GLYPH_D;
            4'hE:    glyph_o = GLYPH_E;
            default: glyph_o = GLYPH_F;
        endcase
    end

endmodule

// File: rtl/tube_ctrl_param.sv
// -----------------------------------------------------------------------------
// tube_ctrl_param
// Parametrised multiplexed seven-segment driver. NUM_GROUPS segment buses are
// scanned in parallel, each over DIGITS_PER_GROUP digits, paced by an internal
// scan tick. Supports per-digit decimal point, blanking and blink, per-group
// leading-zero suppression and a tear-free update handshake that commits new
// contents only at frame boundaries.
//
// Ports (N = NUM_GROUPS*DIGITS_PER_GROUP):
//   clk         in   1             system clock
//   rst_n       in   1             asynchronous active-low reset
//   data        in   4*N           hex nibble per digit
//   dp_en       in   N             decimal point per digit
//   blank_mask  in   N             force digit dark
//   blink_mask  in   N             digit blinks when blink_en
//   lzs_en      in   1             leading-zero suppression
//   blink_en    in   1             blink enable
//   upd_req     in   1             capture the inputs above
//   upd_busy    out  1             capture pending, upd_req ignored
//   upd_done    out  1             pulse when new contents go live
//   tube_scan   out  N             digit enables, active-low
//   tube_seg    out  8*NUM_GROUPS  glyph per group, active-high
// -----------------------------------------------------------------------------
module tube_ctrl_param
    import tube_ctrl_param_pkg::*;
#(
    parameter int SCAN_DIV         = TUBE_SCAN_DIV,
    parameter int NUM_GROUPS       = 2,
    parameter int DIGITS_PER_GROUP = 4,
    parameter int BLINK_FRAMES     = TUBE_BLINK_FRAMES
)(
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [4*NUM_GROUPS*DIGITS_PER_GROUP-1:0] data,
    input  logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]   dp_en,
    input  logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]   blank_mask,
    input  logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]   blink_mask,
    input  logic                                     lzs_en,
    input  logic                                     blink_en,
    input  logic                                     upd_req,
    output logic                                     upd_busy,
    output logic                                     upd_done,
    output logic [NUM_GROUPS*DIGITS_PER_GROUP-1:0]   tube_scan,
    output logic [8*NUM_GROUPS-1:0]                  tube_seg
);

    localparam int N      = NUM_GROUPS * DIGITS_PER_GROUP;
    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int SLOT_W = $clog2(DIGITS_PER_GROUP);
    localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // Packed contents: {data, dp_en, blank_mask, blink_mask, lzs_en, blink_en}
    localparam int CW     = 7 * N + 2;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(DIGITS_PER_GROUP - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLINK_FRAMES - 1);

    // Scan pattern for a slot: in every group the digit at that slot is low.
    function automatic logic [N-1:0] scanFor(input logic [SLOT_W-1:0] s);
        logic [N-1:0] v;
        v = '1;
        for (int g = 0; g < NUM_GROUPS; g++) begin
            v[g * DIGITS_PER_GROUP + int'(s)] = 1'b0;
        end
        return v;
    endfunction

    logic [DIV_W-1:0]  divCnt_q,   divCnt_d;
    logic [SLOT_W-1:0] slot_q,     slot_d;
    logic [BLK_W-1:0]  blinkCnt_q, blinkCnt_d;
    blinkPhase_t       phase_q,    phase_d;
    logic [CW-1:0]     live_q,     live_d;
    logic [CW-1:0]     stage_q;
    logic              busy_q;
    logic              done_q;
    logic [N-1:0]      scan_q,     scan_d;
    logic [8*NUM_GROUPS-1:0] seg_q, seg_d;

    logic          tick;
    logic          boundary;
    logic          capture;
    logic          commit;
    logic [CW-1:0] contentsIn;

    logic [4*N-1:0] nData;
    logic [N-1:0]   nDp;
    logic [N-1:0]   nBlank;
    logic [N-1:0]   nBlinkMask;
    logic           nLzs;
    logic           nBlinkEn;

    assign contentsIn = {data, dp_en, blank_mask, blink_mask, lzs_en, blink_en};

    // Timing backbone: the prescaler produces the tick, the tick advances the
    // slot, and the slot wrapping back to 0 marks the frame boundary where the
    // pending update commits and the blink counter advances.
    always_comb begin
        tick       = (divCnt_q == DIV_LAST);
        boundary   = tick && (slot_q == SLOT_LAST);
        capture    = upd_req && !busy_q;
        commit     = boundary && busy_q;
        divCnt_d   = tick ? '0 : divCnt_q + DIV_W'(1);
        slot_d     = tick ? slot_q + SLOT_W'(1) : slot_q;
        blinkCnt_d = blinkCnt_q;
        phase_d    = phase_q;
        if (boundary) begin
            if (blinkCnt_q == BLK_LAST) begin
                blinkCnt_d = '0;
                phase_d    = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                blinkCnt_d = blinkCnt_q + BLK_WD();
            end
        end
        live_d = commit ? stage_q : live_q;
    end

    function automatic logic [BLK_W-1:0] BLK_WD();
        return BLK_W'(1);
    endfunction

    // The output registers load on the tick edge and must already reflect the
    // contents and phase that take effect on that same edge, so the slot-0
    // glyph of a freshly committed frame is built from the next-state values.
    assign nData      = live_d[CW-1 -: 4*N];
    assign nDp        = live_d[3*N+1 -: N];
    assign nBlank     = live_d[2*N+1 -: N];
    assign nBlinkMask = live_d[N+1 -: N];
    assign nLzs       = live_d[1];
    assign nBlinkEn   = live_d[0];

    assign scan_d = scanFor(slot_d);

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_group
        logic [3:0]                  nib;
        logic [7:0]                  glyph;
        logic [7:0]                  segOut;
        logic [DIGITS_PER_GROUP-1:0] supp;
        logic                        dark;
        int                          idx;

        hex_glyph u_glyph (
            .nibble_i (nib),
            .glyph_o  (glyph)
        );

        // Leading-zero suppression walks from the top slot downward; a slot is
        // suppressed while every nibble from the top down to it is zero. Slot 0
        // is never part of the walk so a value of zero still shows one digit.
        always_comb begin
            logic allZero;
            allZero = 1'b1;
            supp    = '0;
            for (int k = DIGITS_PER_GROUP - 1; k >= 1; k--) begin
                allZero = allZero && (nData[4 * (g * DIGITS_PER_GROUP + k) +: 4] == 4'h0);
                supp[k] = allZero;
            end
        end

        // Decorate the decoded glyph for the digit about to be scanned.
        always_comb begin
            idx    = g * DIGITS_PER_GROUP + int'(slot_d);
            nib    = nData[4 * idx +: 4];
            dark   = nBlank[idx]
                   || (nBlinkEn && nBlinkMask[idx] && (phase_d == PHASE_OFF))
                   || (nLzs && supp[slot_d]);
            segOut = dark ? GLYPH_BLANK : (glyph | {7'b0, nDp[idx]});
        end

        assign seg_d[8 * g +: 8] = segOut;
    end

    // All state; the scan and segment outputs change only together on the tick
    // edge so the digit enable and its glyph never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divCnt_q   <= '0;
            slot_q     <= '0;
            blinkCnt_q <= '0;
            phase_q    <= PHASE_ON;
            live_q     <= '0;
            stage_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            scan_q     <= scanFor('0);
            seg_q      <= {NUM_GROUPS{GLYPH_ZERO}};
        end else begin
            divCnt_q   <= divCnt_d;
            slot_q     <= slot_d;
            blinkCnt_q <= blinkCnt_d;
            phase_q    <= phase_d;
            live_q     <= live_d;
            if (capture) begin
                stage_q <= contentsIn;
            end
            busy_q <= capture || (busy_q && !commit);
            done_q <= commit;
            if (tick) begin
                scan_q <= scan_d;
                seg_q  <= seg_d;
            end
        end
    end

    assign upd_busy  = busy_q;
    assign upd_done  = done_q;
    assign tube_scan = scan_q;
    assign tube_seg  = seg_q;

endmodule

// File: doc/tube_ctrl_param.md
# tube_ctrl_param

Parametrised multiplexed seven-segment driver and successor to the fixed 8-digit tube driver. It drives NUM_GROUPS segment buses in parallel, each scanning DIGITS_PER_GROUP digits, from a single clock with a scan-enable tick instead of a derived clock. Adds:
- per-digit decimal point, blanking and blink;
- per-group leading-zero suppression;
- a tear-free update handshake that commits new contents only at frame boundaries.

It sits between the CPU's memory-mapped display register and the board's tube pins.

## Interface
- SCAN_DIV, 50000: clk cycles per digit slot; legal range ≥ 2.
- NUM_GROUPS, 2: parallel segment buses (left/right).
- DIGITS_PER_GROUP, 4: digits scanned per bus; power of two, ≥ 2.
- BLINK_FRAMES, 64: frames per blink half-period; ≥ 1.
- N = NUM_GROUPS*DIGITS_PER_GROUP (derived, not overridable).

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset, asynchronous assert, active-low
- data  in  4*N  hex nibbles; nibble i belongs to digit i; digit g*DIGITS_PER_GROUP+k is group g, slot k
- dp_en  in  N  decimal point on per digit
- blank_mask  in  N  force digit dark
- blink_mask  in  N  digit blinks when blink_en
- lzs_en  in  1  leading-zero suppression
- blink_en  in  1  blink enable
- upd_req  in  1  request capture of all inputs above
- upd_busy  out  1  capture pending; upd_req ignored while high
- upd_done  out  1  one-cycle pulse when the new contents go live
- tube_scan  out  N  digit enables, active-low
- tube_seg  out  8*NUM_GROUPS  glyph of group g on [8g+7:8g], active-high

## Operation
- Prescaler `div_cnt` counts 0..SCAN_DIV-1. `tick` is asserted when div_cnt == SCAN_DIV-1.
- Slot index `slot` (log2 DIGITS_PER_GROUP bits) increments on tick and wraps to 0.
  - The wrap edge is the frame boundary.
  - In every group, slot k enables digit g*DIGITS_PER_GROUP+k; exactly one digit per group is low at any time.
- Contents registers (`live`): data, dp_en, blank_mask, blink_mask, lzs_en, blink_en. Reset value is all zero.
- Update handshake:
  - upd_req high while upd_busy low: all inputs copied to `stage`, and upd_busy is set on the next edge.
  - At the next frame boundary, stage is copied to live, upd_busy is cleared and upd_done pulses.
  - upd_req while upd_busy is high is dropped; stage is unchanged.
- Glyph for a digit:
  - Dark (8'h00) if any of these holds:
    - its blank_mask bit is set;
    - blink_en is set, its blink_mask bit is set, and blink phase = off;
    - lzs_en is set and the digit is a suppressed leading zero.
  - Otherwise, the hex glyph of its nibble, with dp bit 0 ORed from dp_en.
- Leading-zero suppression is per group. Within a group, scanning from the top slot downward, zero nibbles are dark until the first non-zero nibble. Slot 0 is never suppressed.
- Blink:
  - A frame counter counts 0..BLINK_FRAMES-1 at frame boundaries.
  - Phase toggles on wrap; phase resets to on.
  - The blink counter keeps running while blink_en is low.

## Timing
- Reset values:
  - div_cnt = 0, slot = 0, phase = on.
  - upd_busy = 0, upd_done = 0.
  - tube_scan has slot-0 digits low, all other bits high.
  - tube_seg = ZERO glyph per group.
- tube_scan and tube_seg are registered and change on the same edge (the tick edge), so there is no ghosting skew.
- Each digit stays lit for exactly SCAN_DIV cycles. A frame lasts DIGITS_PER_GROUP*SCAN_DIV cycles.
- Commit latency: upd_done fires on the frame-boundary edge after the capture edge.
  - The minimum is 1 cycle after capture (capture on the edge just before a boundary).
  - The whole new frame, including its slot 0, shows new contents.
- If upd_req is sampled on the boundary edge itself, capture happens on that edge and commit happens at the following boundary.
- upd_busy falls on the same edge as upd_done rises. A new upd_req is accepted on the next cycle.
- Asynchronous reset mid-frame or mid-update discards stage and returns everything to reset values. No upd_done is emitted.

## Structure
- Glyph constants ZERO..F plus BLANK = 8'h00 live in the shared parameters header.
  - Bit 0 is dp and is clear in every glyph.
  - The new constants TUBE_SCAN_DIV and TUBE_BLINK_FRAMES also go in the header.
- Sub-module `hex_glyph`: combinational 4-bit nibble → 8-bit glyph, one instance per group.

## Test plan
1. SCAN_DIV=4, 2×4, reset release with data=0 → tube_scan=8'hEE, tube_seg per group=ZERO. tube_scan steps EE→DD→BB→77→EE with period 4 clk; scan=DD at cycle 4.
2. upd_req with data=32'h5678_9ABC, dp_en=8'h01 → upd_busy=1 next cycle; upd_done at the next boundary. That frame shows C|dp, B, A, 9 on right and 8, 7, 6, 5 on left.
3. lzs_en=1, data=32'h0010_0000 → left group slot 3 dark, slot 2 dark, slot 1 = ONE, slot 0 = ZERO; right group slots 3..1 dark, slot 0 = ZERO.
4. BLINK_FRAMES=2, blink_en=1, blink_mask=8'h80 → digit 7 dark on frames 2–3, lit on frames 0–1 and 4–5; others always lit.
5. Second upd_req while busy with different data → ignored; the first data commits; a single upd_done.
6. rst_n low mid-frame with upd_busy=1 → immediate reset values; no upd_done after release.
